// File: rtl/mips_pipeline_mem_access_pkg.sv
// rtl/mips_pipeline_mem_access_pkg.sv - shared size codes, FSM encoding and bus widths
package mips_pipeline_mem_access_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Size code 3 is illegal and always reported as a fault.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lo[0];
      SIZE_WORD: bad = |lo;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_mem_lane.sv
// rtl/mips_mem_lane.sv - big-endian byte-lane steering for stores and load extraction/extension
module mips_mem_lane
  import mips_pipeline_mem_access_pkg::*;
(
  input  logic [1:0]            addr_lo,
  input  logic [1:0]            size,
  input  logic                  is_signed,
  input  logic [BUS_DATA_W-1:0] store_data,
  input  logic [BUS_DATA_W-1:0] rd_data,
  output logic [BUS_BE_W-1:0]   byte_en,
  output logic [BUS_DATA_W-1:0] wr_data,
  output logic [BUS_DATA_W-1:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Offset k lives on lane 3-k, so offset 0 is the most significant byte.
  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = rd_data[31:24];
      2'd1:    sel_byte = rd_data[23:16];
      2'd2:    sel_byte = rd_data[15:8];
      default: sel_byte = rd_data[7:0];
    endcase
    sel_half = addr_lo[1] ? rd_data[15:0] : rd_data[31:16];
  end

  always_comb begin
    byte_en   = '0;
    wr_data   = '0;
    load_data = '0;
    case (size)
      SIZE_BYTE: begin
        byte_en   = 4'b1000 >> addr_lo;
        wr_data   = {4{store_data[7:0]}};
        load_data = {{24{is_signed & sel_byte[7]}}, sel_byte};
      end
      SIZE_HALF: begin
        byte_en   = addr_lo[1] ? 4'b0011 : 4'b1100;
        wr_data   = {2{store_data[15:0]}};
        load_data = {{16{is_signed & sel_half[15]}}, sel_half};
      end
      SIZE_WORD: begin
        byte_en   = 4'b1111;
        wr_data   = store_data;
        load_data = rd_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_pipeline_mem_access.sv
// rtl/mips_pipeline_mem_access.sv - MEM stage: one req/ack bus transaction per load/store, stalls while pending
module mips_pipeline_mem_access
  import mips_pipeline_mem_access_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exValid,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [1:0]            memSize,
  input  logic                  memSigned,
  input  logic [BUS_ADDR_W-1:0] address,
  input  logic [BUS_DATA_W-1:0] storeData,
  output logic                  busReq,
  output logic                  busWe,
  output logic [BUS_ADDR_W-1:0] busAddr,
  output logic [BUS_BE_W-1:0]   busByteEn,
  output logic [BUS_DATA_W-1:0] busWData,
  input  logic                  busAck,
  input  logic [BUS_DATA_W-1:0] busRData,
  output logic [BUS_DATA_W-1:0] memOut,
  output logic                  stall,
  output logic                  fault
);

  state_t state, state_nxt;

  logic access;
  logic misalign;
  logic in_idle;

  logic [1:0] req_lo;
  logic [1:0] req_size;
  logic       req_signed;
  logic       req_write;

  logic [1:0]            lane_lo;
  logic [1:0]            lane_size;
  logic                  lane_signed;
  logic [BUS_BE_W-1:0]   lane_be;
  logic [BUS_DATA_W-1:0] lane_wd;
  logic [BUS_DATA_W-1:0] lane_ld;

  assign access   = exValid & (memRead | memWrite);
  assign misalign = is_misaligned(memSize, address[1:0]);
  assign in_idle  = (state == ST_IDLE);
  assign stall    = access & ~misalign & (state != ST_DONE);

  // Live fields steer store lanes at capture; captured fields steer load extraction.
  assign lane_lo     = in_idle ? address[1:0] : req_lo;
  assign lane_size   = in_idle ? memSize      : req_size;
  assign lane_signed = in_idle ? memSigned    : req_signed;

  mips_mem_lane u_lane (
    .addr_lo    (lane_lo),
    .size       (lane_size),
    .is_signed  (lane_signed),
    .store_data (storeData),
    .rd_data    (busRData),
    .byte_en    (lane_be),
    .wr_data    (lane_wd),
    .load_data  (lane_ld)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (access && !misalign) state_nxt = ST_REQ;
      ST_REQ:  if (busAck) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      busReq     <= 1'b0;
      busWe      <= 1'b0;
      busAddr    <= '0;
      busByteEn  <= '0;
      busWData   <= '0;
      memOut     <= '0;
      fault      <= 1'b0;
      req_lo     <= '0;
      req_size   <= '0;
      req_signed <= 1'b0;
      req_write  <= 1'b0;
    end else begin
      state <= state_nxt;
      fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (misalign) begin
              fault <= 1'b1;
            end else begin
              busReq     <= 1'b1;
              busWe      <= memWrite;
              busAddr    <= {address[BUS_ADDR_W-1:2], 2'b00};
              busByteEn  <= memWrite ? lane_be : 4'b1111;
              busWData   <= memWrite ? lane_wd : '0;
              req_lo     <= address[1:0];
              req_size   <= memSize;
              req_signed <= memSigned;
              req_write  <= memWrite;
            end
          end
        end
        ST_REQ: begin
          if (busAck) begin
            busReq <= 1'b0;
            busWe  <= 1'b0;
            memOut <= req_write ? '0 : lane_ld;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_pipeline_mem_access.sv
// tb/tb_mips_pipeline_mem_access.sv - directed vectors for the MEM-stage bus FSM
module tb_mips_pipeline_mem_access;

  logic        clock = 1'b0;
  logic        reset;
  logic        exValid;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  memSize;
  logic        memSigned;
  logic [31:0] address;
  logic [31:0] storeData;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busByteEn;
  logic [31:0] busWData;
  logic        busAck;
  logic [31:0] busRData;
  logic [31:0] memOut;
  logic        stall;
  logic        fault;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mips_pipeline_mem_access dut (
    .clock     (clock),
    .reset     (reset),
    .exValid   (exValid),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .memSize   (memSize),
    .memSigned (memSigned),
    .address   (address),
    .storeData (storeData),
    .busReq    (busReq),
    .busWe     (busWe),
    .busAddr   (busAddr),
    .busByteEn (busByteEn),
    .busWData  (busWData),
    .busAck    (busAck),
    .busRData  (busRData),
    .memOut    (memOut),
    .stall     (stall),
    .fault     (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    exValid   = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memSize   = 2'd0;
    memSigned = 1'b0;
    address   = '0;
    storeData = '0;
    busAck    = 1'b0;
    busRData  = '0;
  endtask

  // Starts in IDLE #1 after an edge; ends back in IDLE #1 after an edge.
  task automatic run_access(input string tag, input logic wr, input logic [1:0] sz,
                            input logic sg, input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rdat, input int waits,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] exp_out);
    int stalls = 0;
    exValid   = 1'b1;
    memRead   = ~wr;
    memWrite  = wr;
    memSize   = sz;
    memSigned = sg;
    address   = addr;
    storeData = sd;
    #1;
    if (stall) stalls++;
    tick();
    check({tag, ".busReq"}, busReq, 1);
    check({tag, ".busWe"}, busWe, wr);
    check({tag, ".busAddr"}, busAddr, exp_addr);
    check({tag, ".busByteEn"}, busByteEn, exp_be);
    check({tag, ".busWData"}, busWData, exp_wd);
    for (int w = 0; w < waits; w++) begin
      if (stall) stalls++;
      tick();
    end
    check({tag, ".busAddr_held"}, busAddr, exp_addr);
    if (stall) stalls++;
    busAck   = 1'b1;
    busRData = rdat;
    tick();
    busAck   = 1'b0;
    busRData = 32'h5A5A_5A5A;
    check({tag, ".done_stall"}, stall, 0);
    check({tag, ".done_busReq"}, busReq, 0);
    check({tag, ".memOut"}, memOut, exp_out);
    check({tag, ".stall_cycles"}, stalls, 2 + waits);
    exValid = 1'b0;
    tick();
    check({tag, ".memOut_hold"}, memOut, exp_out);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #12;
    check("rst.busReq", busReq, 0);
    check("rst.busWe", busWe, 0);
    check("rst.busAddr", busAddr, 0);
    check("rst.busByteEn", busByteEn, 0);
    check("rst.busWData", busWData, 0);
    check("rst.memOut", memOut, 0);
    check("rst.fault", fault, 0);
    check("rst.stall", stall, 0);
    tick();
    reset = 1'b0;
    tick();

    // misaligned lw: one-cycle fault, no bus activity
    exValid = 1'b1; memRead = 1'b1; memSize = 2'd2; address = 32'h102;
    #1;
    check("lw_mis.stall", stall, 0);
    tick();
    exValid = 1'b0;
    check("lw_mis.fault", fault, 1);
    check("lw_mis.busReq", busReq, 0);
    tick();
    check("lw_mis.fault_drop", fault, 0);
    check("lw_mis.busReq2", busReq, 0);
    check("lw_mis.memOut", memOut, 0);

    // illegal size 3 at an aligned address
    exValid = 1'b1; memSize = 2'd3; address = 32'h100;
    #1;
    check("sz3.stall", stall, 0);
    tick();
    exValid = 1'b0;
    check("sz3.fault", fault, 1);
    check("sz3.busReq", busReq, 0);
    tick();

    // reset in the second REQ cycle, then a late ack
    exValid = 1'b1; memRead = 1'b1; memSize = 2'd2; address = 32'h100;
    tick();
    check("abort.busReq_req1", busReq, 1);
    tick();
    reset = 1'b1;
    #1;
    check("abort.busReq_async", busReq, 0);
    tick();
    reset = 1'b0;
    exValid = 1'b0;
    busAck = 1'b1; busRData = 32'hCAFE_F00D;
    tick();
    busAck = 1'b0;
    tick();
    check("abort.memOut", memOut, 0);
    check("abort.busReq", busReq, 0);
    check("abort.stall", stall, 0);
    idle_inputs();

    //          tag     wr    sz    sg    addr        storeData     busRData      w  busAddr       be       busWData      memOut
    run_access("lw",   1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 2, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF);
    run_access("lb",   1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h11223380, 0, 32'h100, 4'b1111, 32'h0,        32'hFFFFFF80);
    run_access("lbu",  1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h11223380, 0, 32'h100, 4'b1111, 32'h0,        32'h00000080);
    run_access("lh",   1'b0, 2'd1, 1'b1, 32'h202, 32'h0,        32'hAAAA8001, 1, 32'h200, 4'b1111, 32'h0,        32'hFFFF8001);
    run_access("lhu",  1'b0, 2'd1, 1'b0, 32'h200, 32'h0,        32'hAAAA8001, 0, 32'h200, 4'b1111, 32'h0,        32'h0000AAAA);
    run_access("lb1",  1'b0, 2'd0, 1'b1, 32'h401, 32'h0,        32'h1234_5678, 0, 32'h400, 4'b1111, 32'h0,       32'h00000034);
    run_access("sb",   1'b1, 2'd0, 1'b0, 32'h301, 32'h000000A5, 32'h0,        0, 32'h300, 4'b0100, 32'hA5A5A5A5, 32'h0);
    run_access("sh",   1'b1, 2'd1, 1'b0, 32'h502, 32'hFFFF1234, 32'h0,        1, 32'h500, 4'b0011, 32'h12341234, 32'h0);
    run_access("sw",   1'b1, 2'd2, 1'b0, 32'h604, 32'h89ABCDEF, 32'h0,        0, 32'h604, 4'b1111, 32'h89ABCDEF, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
